// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the radix-2 restoring divider on the ex_div interface.
package iterative_divider_pkg;

    localparam int unsigned DIV_ITERATIONS      = 32;
    localparam int unsigned DIV_OP_UNSIGNED_BIT = 1;
    localparam int unsigned DIV_OP_MOD_BIT      = 0;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider serving div.w/mod.w/div.wu/mod.wu; quotient and remainder produced together.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero or |dividend|<|divisor| finishes in one cycle.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  is_running,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0] remainder_out
);

    div_state_t r_state, w_next_state;

    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rem, r_quo, r_dvs, r_dvd_raw;
    logic                  r_q_neg, r_r_neg;

    logic                  w_signed, w_dvd_neg, w_dvs_neg, w_early, w_last, w_div_zero;
    logic [DATA_WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_rem_next, w_quo_next;
    logic [DATA_WIDTH:0]   w_shift, w_diff;
    logic                  w_unused_op_mod;

    assign w_unused_op_mod = op[DIV_OP_MOD_BIT];

    assign w_signed  = ~op[DIV_OP_UNSIGNED_BIT];
    assign w_dvd_neg = w_signed & dividend[DATA_WIDTH-1];
    assign w_dvs_neg = w_signed & divisor[DATA_WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs = w_dvs_neg ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (divisor == '0) || (w_dvd_abs < w_dvs_abs);
`else
    assign w_early = 1'b0;
`endif

    // Partial remainder stays below the divisor, so bit DATA_WIDTH of the 33-bit difference is the borrow.
    assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
    assign w_quo_next = {r_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
    assign w_last     = (r_cnt == CNT_WIDTH'(DIV_ITERATIONS - 1));
    assign w_div_zero = (r_dvs == '0);

    always_comb begin
        w_next_state = r_state;
        is_running   = 1'b0;
        done         = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) w_next_state = w_early ? DIV_DONE : DIV_RUN;
            end
            DIV_RUN: begin
                is_running = 1'b1;
                if (w_last) w_next_state = DIV_DONE;
            end
            DIV_DONE: begin
                done         = 1'b1;
                w_next_state = DIV_IDLE;
            end
            default: w_next_state = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= DIV_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dvd_raw     <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_abs;
                        r_dvs     <= w_dvs_abs;
                        r_dvd_raw <= dividend;
                        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg   <= w_dvd_neg;
                        if (w_early) begin
                            quotient_out  <= (divisor == '0) ? '1 : '0;
                            remainder_out <= dividend;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (w_div_zero) begin
                            quotient_out  <= '1;
                            remainder_out <= r_dvd_raw;
                        end else begin
                            quotient_out  <= r_q_neg ? -w_quo_next : w_quo_next;
                            remainder_out <= r_r_neg ? -w_rem_next : w_rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: stimulus pushes expected results, a monitor checks them on done.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic        is_running, done;
    logic [31:0] quotient_out, remainder_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          issue;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        bit          early;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    bit   prev_done = 1'b0;

    iterative_divider #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .dividend      (dividend),
        .divisor       (divisor),
        .is_running    (is_running),
        .done          (done),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_pulse: done high two cycles in a row, required one cycle");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got q=%h r=%h with nothing outstanding", quotient_out, remainder_out);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (quotient_out !== e.q) begin
                    errors++;
                    $display("FAIL quotient: got %h required %h", quotient_out, e.q);
                end
                if (remainder_out !== e.r) begin
                    errors++;
                    $display("FAIL remainder: got %h required %h", remainder_out, e.r);
                end
                if (cyc - e.issue != e.lat) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", cyc - e.issue, e.lat);
                end
            end
        end
        prev_done = done;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    function automatic int exp_lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
        return early ? 1 : 33;
`else
        return 33 + (early ? 0 : 0);
`endif
    endfunction

    task automatic add(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input bit early);
        vec_t v;
        v.op = o; v.dvd = a; v.dvs = b; v.q = q; v.r = r; v.early = early;
        vecs.push_back(v);
    endtask

    // Issue one operation; optionally pulse a bogus start (9/3) mid-flight at iteration 'inject'.
    task automatic run_one(input vec_t v, input int inject);
        exp_t e;
        int   n_run = 0;
        bit   got   = 1'b0;
        int   lat;
        lat = exp_lat(v.early);
        @(negedge clk);
        op = v.op; dividend = v.dvd; divisor = v.dvs; start = 1'b1;
        e.q = v.q; e.r = v.r; e.lat = lat; e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == inject) begin
                start = 1'b1; op = 2'b00; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (is_running) n_run++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        check("running_cycles", n_run, (lat == 1) ? 32'd0 : 32'd32);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;

        add(2'b00, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        add(2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        add(2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
        add(2'b10, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0);
        add(2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
        add(2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);
        add(2'b10, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
        add(2'b10, 32'd3,          32'd10,         32'd0,          32'd3,          1'b1);
        add(2'b01, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b1);
        add(2'b11, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_q", quotient_out, 32'd0);
        check("reset_r", remainder_out, 32'd0);
        check("reset_run", {31'd0, is_running}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_one(vecs[i], -1);

        // Second start mid-RUN must be ignored.
        v.op = 2'b00; v.dvd = 32'd1000; v.dvs = 32'd7; v.q = 32'd142; v.r = 32'd6; v.early = 1'b0;
        run_one(v, 5);

        // Reset at step 10 discards the in-flight operation.
        @(negedge clk);
        op = 2'b00; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_q", quotient_out, 32'd0);
        check("midrst_r", remainder_out, 32'd0);
        check("midrst_run", {31'd0, is_running}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        v.op = 2'b00; v.dvd = 32'd20; v.dvs = 32'd6; v.q = 32'd3; v.r = 32'd2; v.early = 1'b0;
        run_one(v, -1);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring integer divider; slave side of the ex_div interface, directly downstream of the execute stage.
- Execute drives operands, op and a start pulse, stalls while is_running, then consumes quotient_out/remainder_out on done.
- Serves LoongArch div.w/mod.w/div.wu/mod.wu; quotient and remainder are produced together, execute selects which one to use.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  op[1]=1 unsigned, 0 signed; op[0]=quotient/remainder select, ignored internally.
- dividend  input  32  sampled with start.
- divisor  input  32  sampled with start.
- is_running  output  1  high in RUN.
- done  output  1  one-cycle result-valid pulse.
- quotient_out  output  32  quotient, held until next accepted start.
- remainder_out  output  32  remainder, held until next accepted start.

Behaviour:
- Reset: state=IDLE, counter=0, is_running=0, done=0, quotient_out=0, remainder_out=0. Reset wins over any operation in flight, including mid-RUN; the partial result is discarded.
- States and transitions:
  - IDLE->RUN on start (edge E0). Latch |dividend| and |divisor| (absolute values only when signed), plus q_neg=sign(dvd)^sign(dvs) and r_neg=sign(dvd). In unsigned mode q_neg=r_neg=0.
  - RUN: one restoring step per edge. Shift {rem,quo} left 1; if rem>=divisor, subtract and set quo LSB. Use a 33-bit subtract so there is no overflow. Counter increments each step.
  - After 32 steps (edge E32) -> DONE. Sign-corrected results are registered at that edge.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start sampled at E0, done high in the cycle following E32 (33 cycles).
- start while RUN or DONE is ignored; operand changes after E0 are ignored.
- Sign fix: quotient negated if q_neg; remainder negated if r_neg (remainder takes the sign of the dividend).
- INT_MIN/-1 signed: quotient 0x80000000, remainder 0 (falls out of unsigned magnitude arithmetic).
- Divisor==0 (any op): quotient_out=0xFFFFFFFF, remainder_out=dividend as latched (raw, no sign fix). Full RUN latency still applies.
- Outputs change only at the DONE-entry edge or on reset.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at E0, if divisor==0 or |dividend|<|divisor| (unsigned magnitude compare), go IDLE->DONE directly.
  - Results: quotient=0 (0xFFFFFFFF for divide-by-zero); remainder=dividend unchanged.
  - done is high in the cycle after E0; is_running stays 0.
- Not defined: every operation takes the full 33-cycle latency.

Decomposition:
- pipeline_types gains:
  - div_state_t enum {DIV_IDLE, DIV_RUN, DIV_DONE}.
  - Constants DIV_OP_UNSIGNED_BIT=1 and DIV_OP_MOD_BIT=0.
  - DIV_ITERATIONS=32.
- Single module; no sub-module required. The restoring step stays inline.

Test Plan:
- Signed 100/7 -> q=14, r=2; done in the 33rd cycle after start, is_running high in the 32 cycles before done.
- Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=1.
- Unsigned 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- Divide-by-zero, signed -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB. With DIV_EARLY_OUT_EN, done arrives one cycle after start.
- Second start with 9/3 pulsed mid-RUN -> ignored; first result delivered unchanged.
- rst asserted at step 10 -> next edge all outputs 0, IDLE. A new start 20/6 afterwards gives q=3, r=2 with full latency.
